// File: rtl/display_arbiter_pkg.sv
// Shared types and helpers for the seven-segment display arbiter.
// The rotating search is sized for the largest supported requester count.
package display_pkg;

  localparam int DISP_W = 16;
  localparam int MAX_N  = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  // First set bit of req[0..n-1], searching start, start+1, ... wrapping mod n.
  function automatic logic rr_first(
    input  logic [MAX_N-1:0] req,
    input  int               start,
    input  int               n,
    output int               idx
  );
    logic found;
    int   j;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < MAX_N; k++) begin
      if (k < n && !found) begin
        j = (start + k) % n;
        if (req[j]) begin
          found = 1'b1;
          idx   = j;
        end
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after i_ptr,
// ignoring any requester set in i_excl.
module rr_pick
  import display_pkg::*;
#(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  input  logic [N-1:0]  i_excl,
  output logic [PW-1:0] o_idx,
  output logic          o_found
);

  logic [MAX_N-1:0] w_req8;
  int               w_idx_int;

  assign w_req8 = MAX_N'(i_req & ~i_excl);

  always_comb begin
    w_idx_int = 0;
    o_found   = rr_first(w_req8, int'(i_ptr), N, w_idx_int);
    o_idx     = PW'(w_idx_int);
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 4-digit seven-segment display between N requesters using
// round-robin arbitration with a minimum dwell per grant.
module display_arbiter
  import display_pkg::*;
#(
  parameter int N     = 3,
  parameter int DWELL = 50_000_000,
  parameter int CW    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N-1:0]          req,
  input  logic [DISP_W*N-1:0]   req_data,
  input  logic                  lock,
  output logic [N-1:0]          grant,
  output logic [DISP_W-1:0]     disp_data,
  output logic                  switch_pulse
);

  localparam int            PW       = $clog2(N);
  localparam logic [CW-1:0] DWELL_M1 = CW'(DWELL - 1);

  state_t            r_state;
  logic [PW-1:0]     r_ptr;
  logic [PW-1:0]     r_owner;
  logic [CW-1:0]     r_cnt;
  logic [N-1:0]      r_grant;
  logic [DISP_W-1:0] r_disp;
  logic              r_pulse;

  logic [DISP_W-1:0] w_words [N];
  logic [PW-1:0]     w_pick;
  logic              w_found;
  logic [PW-1:0]     w_nxt_ptr;
  logic [N-1:0]      w_onehot;
  logic              w_own_req;

  for (genvar g = 0; g < N; g++) begin : g_words
    assign w_words[g] = req_data[g*DISP_W +: DISP_W];
  end

  // In IDLE r_grant is zero, so excluding it only matters while someone owns.
  rr_pick #(
    .N  (N),
    .PW (PW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .i_excl  (r_grant),
    .o_idx   (w_pick),
    .o_found (w_found)
  );

  assign w_nxt_ptr = (w_pick == PW'(N - 1)) ? '0 : w_pick + 1'b1;
  assign w_onehot  = N'(1) << w_pick;
  assign w_own_req = req[r_owner];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_grant <= '0;
      r_disp  <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_found) begin
            r_state <= ST_OWN;
            r_grant <= w_onehot;
            r_owner <= w_pick;
            r_ptr   <= w_nxt_ptr;
            r_cnt   <= '0;
            r_pulse <= 1'b1;
          end
        end
        ST_OWN: begin
          // Release wins over expiry; the display keeps the last word sampled.
          if (!w_own_req) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_cnt   <= '0;
          end else begin
            r_disp <= w_words[r_owner];
            if (r_cnt == DWELL_M1) begin
              r_cnt <= '0;
              if (!lock && w_found) begin
                r_grant <= w_onehot;
                r_owner <= w_pick;
                r_ptr   <= w_nxt_ptr;
                r_pulse <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant        = r_grant;
  assign disp_data    = r_disp;
  assign switch_pulse = r_pulse;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with N=3, DWELL=4.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req;
  logic [47:0] req_data;
  logic        lock;
  logic [2:0]  grant;
  logic [15:0] disp_data;
  logic        switch_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  display_arbiter #(
    .N     (3),
    .DWELL (4),
    .CW    (32)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_data     (req_data),
    .lock         (lock),
    .grant        (grant),
    .disp_data    (disp_data),
    .switch_pulse (switch_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and settle; outputs then reflect that edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(input string tag, input logic [2:0] g, input logic [15:0] d, input logic p);
    chk({tag, ".grant"}, 16'(grant), 16'(g));
    chk({tag, ".disp"}, disp_data, d);
    chk({tag, ".pulse"}, 16'(switch_pulse), 16'(p));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int own;
    rst_n    = 1'b0;
    req      = 3'b000;
    req_data = '0;
    lock     = 1'b0;

    // Reset and idle
    repeat (3) tick();
    outs("rst", 3'b000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      outs("idle", 3'b000, 16'h0000, 1'b0);
    end

    // Single requester 1
    req_data[31:16] = 16'hBEEF;
    req = 3'b010;
    tick();
    outs("single.grant", 3'b010, 16'h0000, 1'b1);
    tick();
    outs("single.data", 3'b010, 16'hBEEF, 1'b0);
    for (int i = 0; i < 20; i++) begin
      tick();
      outs("single.hold", 3'b010, 16'hBEEF, 1'b0);
    end
    req = 3'b000;
    tick();
    outs("single.rel", 3'b000, 16'hBEEF, 1'b0);

    // Rotation across all three, 4 cycles each
    do_reset();
    outs("rot.rst", 3'b000, 16'h0000, 1'b0);
    req_data = {16'h3333, 16'h2222, 16'h1111};
    req = 3'b111;
    for (int k = 0; k < 16; k++) begin
      tick();
      own = (k / 4) % 3;
      chk("rot.grant", 16'(grant), 16'(3'b001 << own));
      chk("rot.pulse", 16'(switch_pulse), 16'((k % 4) == 0));
      if (k >= 1)
        chk("rot.disp", disp_data, 16'h1111 * 16'(((k - 1) / 4) % 3 + 1));
    end

    // Early release of owner 0 while requester 2 waits
    do_reset();
    req_data = {16'h3333, 16'h2222, 16'h1111};
    req = 3'b101;
    tick();
    outs("early.g0", 3'b001, 16'h0000, 1'b1);
    tick();
    outs("early.c1", 3'b001, 16'h1111, 1'b0);
    req = 3'b100;
    req_data[15:0] = 16'h1234;
    tick();
    outs("early.gap", 3'b000, 16'h1111, 1'b0);
    tick();
    outs("early.g2", 3'b100, 16'h1111, 1'b1);
    tick();
    outs("early.d2", 3'b100, 16'h3333, 1'b0);

    // Lock freezes rotation; release lets the next expiry switch
    do_reset();
    req_data = {16'h3333, 16'h2222, 16'h1111};
    req = 3'b011;
    tick();
    outs("lock.g0", 3'b001, 16'h0000, 1'b1);
    lock = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      outs("lock.hold", 3'b001, 16'h1111, 1'b0);
    end
    lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      outs("lock.wait", 3'b001, 16'h1111, 1'b0);
    end
    tick();
    outs("lock.sw", 3'b010, 16'h1111, 1'b1);
    tick();
    outs("lock.c1", 3'b010, 16'h2222, 1'b0);
    tick();
    outs("lock.c2", 3'b010, 16'h2222, 1'b0);

    // Reset mid-dwell with owner 1 at cnt=2
    rst_n = 1'b0;
    tick();
    outs("midrst", 3'b000, 16'h0000, 1'b0);
    rst_n = 1'b1;
    req = 3'b111;
    tick();
    outs("midrst.first", 3'b001, 16'h0000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
